uart_tx_frame_serializer: RTL and testbench
===========================================

# uart_tx_frame_serializer

Parametrised UART transmit engine: accepts a parallel word over a valid/ready handshake and serialises it as start bit, `DATA_WIDTH` data bits LSB first, optional even/odd parity and one or two stop bits. It owns its own bit-period counter, driven by a runtime prescale value. It drives the registered serial line `Tx_out`, which idles high.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5–16.
- `PRESCALE_WIDTH`, default 16: width of the `Prescale` input.
- `CLK`  in  1: single clock; all state is on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH: word to transmit.
- `Data_Valid`  in  1: request to send `P_DATA`.
- `PAR_EN`  in  1: 1 inserts a parity bit.
- `PAR_TYP`  in  1: 0 selects even parity, 1 selects odd.
- `STOP2`  in  1: 1 sends two stop bits, 0 sends one.
- `Prescale`  in  PRESCALE_WIDTH: clock cycles per bit. A value of 0 is treated as 1.
- `Tx_ready`  out  1: high when a new word can be accepted.
- `Tx_out`  out  1: serial line, registered.
- `frame_done`  out  1: one-cycle pulse at frame end.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Accept: the frame is accepted at a rising edge where `Data_Valid`=1 and `Tx_ready`=1.
  - At that edge the block latches `P_DATA`, `PAR_EN`, `PAR_TYP`, `STOP2` and the effective prescale P.
  - Input changes after that edge have no effect on the current frame.
- Parity bit:
  - Even parity: XOR-reduce of the latched data.
  - Odd parity: the inverse of the even-parity value.
- Bit timing: every bit, in every state, is held on `Tx_out` for exactly P cycles. An internal P-counter and a bit index sequence the bits.
- State transitions:
  - IDLE → START on accept.
  - START → DATA after P cycles.
  - DATA sends bits 0..DATA_WIDTH-1 in that order.
  - After the last data bit: DATA → PARITY if `PAR_EN`, otherwise DATA → STOP.
  - PARITY → STOP after P cycles.
  - STOP holds `Tx_out`=1 for P cycles, or 2P cycles if `STOP2`, then returns to IDLE.
- `Tx_out` value per state: IDLE=1, START=0, DATA=current data bit, PARITY=parity bit, STOP=1.
- `Tx_ready` is 1 only in IDLE.
- `Data_Valid` while busy is ignored. The block has no queue and no error flag.
- Frame length in cycles: P × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2).
- Counter widths: the P-counter is PRESCALE_WIDTH bits; the bit index is clog2(DATA_WIDTH+1) bits. Neither counter may wrap within a bit or frame.

## Timing
- Reset values: `Tx_out`=1, `Tx_ready`=1, `frame_done`=0, state IDLE, all counters 0.
- Reset is applied asynchronously, including mid-frame. The frame is abandoned and `Tx_out` returns high immediately.
- Accept edge k:
  - `Tx_out` goes to 0 and `Tx_ready` goes to 0, both registered at edge k.
  - The start bit occupies cycles k..k+P-1.
- End edge e is the edge that ends the last stop-bit cycle. At e: `Tx_out`=1 (unchanged), `Tx_ready`←1, `frame_done`←1 for exactly one cycle.
- The earliest next accept is edge e+1, so back-to-back frames have one extra idle-high cycle between them.
- Each output changes only at rising edges; there is no combinational path from inputs to outputs.
- P=1 case: each bit lasts a single cycle, and the block must still hit the exact frame length.

## Test plan
- Reset: assert `RST` with `CLK` stopped → `Tx_out`=1, `Tx_ready`=1, `frame_done`=0 immediately.
- Basic frame:
  - Setup: DATA_WIDTH=8, P=4, PAR_EN=0, STOP2=0, `P_DATA`=0xA5.
  - Required `Tx_out`, in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `frame_done` pulses 40 cycles after accept.
- Parity and two stops:
  - `P_DATA`=0x07, P=2, PAR_EN=1, PAR_TYP=0, STOP2=1 → parity bit 1, frame 24 cycles.
  - Repeat with PAR_TYP=1 → parity bit 0.
- Streaming:
  - `Data_Valid` held high; `P_DATA` changed 0x55→0x3C mid-frame.
  - First frame is sent as 0x55.
  - Second frame's start bit begins exactly 1 cycle after `frame_done`.
- Mid-frame reset: `RST` pulse during data bit 3 → `Tx_out`=1 asynchronously; after release, a new word is accepted and sent intact.
- Prescale 0: `Prescale`=0, 8N1 frame → total frame 10 cycles, identical to P=1.

Source files
------------

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART transmit serializer with runtime prescale, optional parity and stop2
// Frame fields and the effective prescale are latched at accept, so inputs may change freely mid-frame.
module uart_tx_frame_serializer #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      STOP2,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      Tx_ready,
   output logic                      Tx_out,
   output logic                      frame_done
);

   localparam int IDX_W = $clog2(DATA_WIDTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [PRESCALE_WIDTH-1:0] ONE_P = PRESCALE_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      parity_q, parity_d;
   logic                      par_en_q, par_en_d;
   logic                      stop2_q, stop2_d;
   logic                      tx_out_q, tx_out_d;
   logic                      tx_ready_q, tx_ready_d;
   logic                      frame_done_q, frame_done_d;
   logic                      bit_end;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      presc_d      = presc_q;
      bit_idx_d    = bit_idx_q;
      data_d       = data_q;
      parity_d     = parity_q;
      par_en_d     = par_en_q;
      stop2_d      = stop2_q;
      frame_done_d = 1'b0;
      bit_end      = (cnt_q == (presc_q - ONE_P));

      case (state_q)
         S_IDLE: begin
            if (tx_ready_q && Data_Valid) begin
               state_d   = S_START;
               cnt_d     = '0;
               bit_idx_d = '0;
               data_d    = P_DATA;
               parity_d  = (^P_DATA) ^ PAR_TYP;
               par_en_d  = PAR_EN;
               stop2_d   = STOP2;
               presc_d   = (Prescale == '0) ? ONE_P : Prescale;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + ONE_P;
            end
         end
         S_DATA: begin
            // The data register shifts right so the bit on the line is always data_q[0].
            if (bit_end) begin
               cnt_d  = '0;
               data_d = data_q >> 1;
               if (bit_idx_q == LAST_IDX) begin
                  bit_idx_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + ONE_P;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + ONE_P;
            end
         end
         S_STOP: begin
            // The bit index counts the second stop bit when two are requested.
            if (bit_end) begin
               cnt_d = '0;
               if (stop2_q && (bit_idx_q == '0)) begin
                  bit_idx_d = IDX_W'(1);
               end else begin
                  bit_idx_d    = '0;
                  state_d      = S_IDLE;
                  frame_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + ONE_P;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_START:  tx_out_d = 1'b0;
         S_DATA:   tx_out_d = data_d[0];
         S_PARITY: tx_out_d = parity_d;
         default:  tx_out_d = 1'b1;
      endcase
      tx_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         presc_q      <= '0;
         bit_idx_q    <= '0;
         data_q       <= '0;
         parity_q     <= 1'b0;
         par_en_q     <= 1'b0;
         stop2_q      <= 1'b0;
         tx_out_q     <= 1'b1;
         tx_ready_q   <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         presc_q      <= presc_d;
         bit_idx_q    <= bit_idx_d;
         data_q       <= data_d;
         parity_q     <= parity_d;
         par_en_q     <= par_en_d;
         stop2_q      <= stop2_d;
         tx_out_q     <= tx_out_d;
         tx_ready_q   <= tx_ready_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Tx_out     = tx_out_q;
   assign Tx_ready   = tx_ready_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - scoreboard bench for uart_tx_frame_serializer
// Expected frames are bit patterns written in line order (leftmost bit is sent first).
module tb_uart_tx_frame_serializer;

   logic        CLK;
   logic        RST;
   logic [7:0]  P_DATA;
   logic        Data_Valid;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic        STOP2;
   logic [15:0] Prescale;
   logic        Tx_ready;
   logic        Tx_out;
   logic        frame_done;
   logic        clk_en;

   uart_tx_frame_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .Prescale   (Prescale),
      .Tx_ready   (Tx_ready),
      .Tx_out     (Tx_out),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [15:0] pat;
      int          nbits;
      int          p;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always begin
      #5;
      if (clk_en) CLK = ~CLK;
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] pat, input int nbits, input int p, input int gap);
      exp_t e;
      e.pat   = pat;
      e.nbits = nbits;
      e.p     = p;
      e.gap   = gap;
      return e;
   endfunction

   // Monitor: captures Tx_out from the accept cycle until frame_done, then scores it.
   logic prev_ready = 1'b1;
   logic in_frame   = 1'b0;
   logic done_seen  = 1'b0;
   logic samples[$];
   int   cyc        = 0;
   int   start_cyc  = 0;
   int   last_done  = -100;

   always @(negedge CLK) begin
      cyc++;
      if (RST) begin
         in_frame   = 1'b0;
         done_seen  = 1'b0;
         prev_ready = 1'b1;
         samples.delete();
      end else begin
         if (done_seen) begin
            chk("frame_done_width", int'(frame_done), 0);
            done_seen = 1'b0;
         end
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("frame_len", samples.size(), e.nbits * e.p);
               for (int b = 0; b < e.nbits; b++) begin
                  int bad;
                  bad = 0;
                  for (int j = 0; j < e.p; j++) begin
                     int idx;
                     idx = b * e.p + j;
                     if (idx >= samples.size() || samples[idx] !== e.pat[e.nbits-1-b]) bad++;
                  end
                  chk($sformatf("bit%0d_bad_cycles", b), bad, 0);
               end
               if (e.gap >= 0) chk("start_after_done", start_cyc - last_done, e.gap);
               chk("tx_out_at_done", int'(Tx_out), 1);
               chk("tx_ready_at_done", int'(Tx_ready), 1);
            end
            in_frame  = 1'b0;
            last_done = cyc;
            done_seen = 1'b1;
         end else if (in_frame) begin
            samples.push_back(Tx_out);
         end
         if (prev_ready && !Tx_ready) begin
            in_frame  = 1'b1;
            start_cyc = cyc;
            samples.delete();
            samples.push_back(Tx_out);
         end
         prev_ready = Tx_ready;
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!Tx_ready && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (!Tx_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      repeat (2) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                       input logic [15:0] ps, input logic push, input exp_t e);
      wait_ready();
      if (push) exp_q.push_back(e);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      STOP2      = s2;
      Prescale   = ps;
      Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      chk("accepted_ready_low", int'(Tx_ready), 0);
      P_DATA   = ~d;
      PAR_EN   = ~pe;
      PAR_TYP  = ~pt;
      STOP2    = ~s2;
      Prescale = ps + 16'd5;
   endtask

   initial begin
      int n;
      CLK        = 1'b0;
      clk_en     = 1'b0;
      RST        = 1'b0;
      P_DATA     = '0;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      STOP2      = 1'b0;
      Prescale   = 16'd1;

      #3 RST = 1'b1;
      #1;
      chk("reset_tx_out", int'(Tx_out), 1);
      chk("reset_tx_ready", int'(Tx_ready), 1);
      chk("reset_frame_done", int'(frame_done), 0);
      clk_en = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // 0xA5 8N1, P=4: 40 cycles
      send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1, mk(16'b0101001011, 10, 4, -1));
      wait_empty();

      // 0x07 even parity, two stops, P=2: 24 cycles, parity 1
      send(8'h07, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, mk(16'b011100000111, 12, 2, -1));
      wait_empty();
      // odd parity: parity 0
      send(8'h07, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, mk(16'b011100000011, 12, 2, -1));
      wait_empty();

      // Streaming with Data_Valid held high; P_DATA changes mid-frame
      wait_ready();
      exp_q.push_back(mk(16'b0101010101, 10, 3, -1));
      exp_q.push_back(mk(16'b0001111001, 10, 3, 1));
      P_DATA     = 8'h55;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      STOP2      = 1'b0;
      Prescale   = 16'd3;
      Data_Valid = 1'b1;
      repeat (5) @(negedge CLK);
      P_DATA = 8'h3C;
      n = 0;
      while (exp_q.size() > 1 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      @(negedge CLK);
      Data_Valid = 1'b0;
      chk("stream_second_accepted", int'(Tx_ready), 0);
      wait_empty();

      // Mid-frame reset during data bit 3 of 0x00 (P=2), then an intact frame
      send(8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, mk(16'b0, 10, 2, -1));
      repeat (8) @(negedge CLK);
      chk("data_bit3_low", int'(Tx_out), 0);
      #2 RST = 1'b1;
      #1;
      chk("midreset_tx_out", int'(Tx_out), 1);
      chk("midreset_tx_ready", int'(Tx_ready), 1);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      send(8'hC3, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, mk(16'b0110000111, 10, 2, -1));
      wait_empty();

      // Prescale 0 behaves as 1: 10-cycle frame
      send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, mk(16'b0101001011, 10, 1, -1));
      wait_empty();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
